// File: rtl/event_frag_pkg.sv
// Shared definitions for the event fragmenter: FSM states, header and
// control-word field positions, and error pulse bit indices.
package event_frag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } frag_state_e;

  // Control word layout
  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_TAG_LSB = 20;

  // Field widths
  localparam int TAG_W  = 12;
  localparam int FIDX_W = 12;
  localparam int LEN_W  = 20;

  // Header qword layout
  localparam int HDR_TAG_LSB  = 52;
  localparam int HDR_FIDX_LSB = 40;
  localparam int HDR_LEN_LSB  = 20;
  localparam int HDR_OFF_LSB  = 0;

  // Error pulse bit indices
  localparam int ERR_EARLY = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_ZERO  = 2;
  localparam int ERR_W     = 3;

  // Assemble a fragment header qword from its fields.
  function automatic logic [63:0] build_header(
    input logic [TAG_W-1:0]  tag,
    input logic [FIDX_W-1:0] fidx,
    input logic [LEN_W-1:0]  len,
    input logic [LEN_W-1:0]  off
  );
    logic [63:0] hdr;
    hdr = 64'd0;
    hdr[HDR_TAG_LSB  +: TAG_W]  = tag;
    hdr[HDR_FIDX_LSB +: FIDX_W] = fidx;
    hdr[HDR_LEN_LSB  +: LEN_W]  = len;
    hdr[HDR_OFF_LSB  +: LEN_W]  = off;
    return hdr;
  endfunction

endpackage

// File: rtl/event_fragmenter.sv
// Event fragmenter: splits each event (control word + data qwords) into
// fragments of at most FRAG_QWORDS data qwords, each preceded by a header.
// Data passes straight through; only the header is sourced from registers.
module event_fragmenter
  import event_frag_pkg::*;
#(
  parameter int unsigned FRAG_QWORDS = 1024,
  parameter              ETHCLKTYPE  = "NONE"
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_ctrl_tdata,
  input  logic        s_ctrl_tvalid,
  output logic        s_ctrl_tready,
  input  logic [63:0] s_data_tdata,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  input  logic        s_data_tlast,
  output logic [63:0] m_frag_tdata,
  output logic        m_frag_tvalid,
  input  logic        m_frag_tready,
  output logic        m_frag_tlast,
  output logic [2:0]  err_o,
  output logic [31:0] event_count_o,
  output logic [31:0] frag_count_o
);

  localparam logic [FIDX_W-1:0] FCNT_MAX = FIDX_W'(FRAG_QWORDS);

  frag_state_e        state_q, state_d;
  logic               alive_q;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   off_q, off_d;
  logic [FIDX_W-1:0]  fidx_q, fidx_d;
  logic [FIDX_W-1:0]  fcnt_q, fcnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [31:0]        evt_cnt_q, evt_cnt_d;
  logic [31:0]        frag_cnt_q, frag_cnt_d;

  logic               ctrl_hs_s;
  logic               frag_hs_s;
  logic               data_hs_s;
  logic [FIDX_W-1:0]  fill_s;

  assign ctrl_hs_s = s_ctrl_tvalid & s_ctrl_tready;
  assign frag_hs_s = m_frag_tvalid & m_frag_tready;
  assign data_hs_s = s_data_tvalid & s_data_tready;
  // Data qwords for the next fragment: whatever is left, capped at the fragment size.
  assign fill_s    = (rem_q < {{(LEN_W-FIDX_W){1'b0}}, FCNT_MAX}) ? rem_q[FIDX_W-1:0] : FCNT_MAX;

  assign err_o         = err_q;
  assign event_count_o = evt_cnt_q;
  assign frag_count_o  = frag_cnt_q;

  // Handshake and data-path muxing per state; header in HDR, pass-through in DATA.
  always_comb begin
    s_ctrl_tready = 1'b0;
    s_data_tready = 1'b0;
    m_frag_tvalid = 1'b0;
    m_frag_tdata  = 64'd0;
    m_frag_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low until the first clock edge after reset release.
        s_ctrl_tready = alive_q;
      end
      ST_HDR: begin
        m_frag_tvalid = 1'b1;
        m_frag_tdata  = build_header(tag_q, fidx_q, len_q, off_q);
        // Zero-length event: the header is the whole fragment.
        m_frag_tlast  = (len_q == {LEN_W{1'b0}});
      end
      ST_DATA: begin
        m_frag_tvalid = s_data_tvalid;
        m_frag_tdata  = s_data_tdata;
        s_data_tready = m_frag_tready;
        m_frag_tlast  = (fcnt_q == {{(FIDX_W-1){1'b0}}, 1'b1}) | s_data_tlast;
      end
      ST_DRAIN: begin
        s_data_tready = 1'b1;
      end
      default: begin
        s_ctrl_tready = 1'b0;
      end
    endcase
  end

  // Next-state, event bookkeeping, counters and error pulses.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    len_d      = len_q;
    rem_d      = rem_q;
    off_d      = off_q;
    fidx_d     = fidx_q;
    fcnt_d     = fcnt_q;
    err_d      = {ERR_W{1'b0}};
    evt_cnt_d  = evt_cnt_q;
    frag_cnt_d = frag_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_hs_s) begin
          tag_d     = s_ctrl_tdata[CTRL_TAG_LSB +: TAG_W];
          len_d     = s_ctrl_tdata[CTRL_LEN_LSB +: LEN_W];
          rem_d     = s_ctrl_tdata[CTRL_LEN_LSB +: LEN_W];
          off_d     = {LEN_W{1'b0}};
          fidx_d    = {FIDX_W{1'b0}};
          fcnt_d    = {FIDX_W{1'b0}};
          evt_cnt_d = evt_cnt_q + 32'd1;
          state_d   = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (frag_hs_s) begin
          if (len_q == {LEN_W{1'b0}}) begin
            // Header-only fragment is complete; swallow whatever data the event carries.
            err_d[ERR_ZERO] = 1'b1;
            frag_cnt_d      = frag_cnt_q + 32'd1;
            state_d         = ST_DRAIN;
          end else begin
            fcnt_d  = fill_s;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (data_hs_s) begin
          fcnt_d = fcnt_q - {{(FIDX_W-1){1'b0}}, 1'b1};
          rem_d  = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
          off_d  = off_q + {{(LEN_W-1){1'b0}}, 1'b1};
          if (s_data_tlast) begin
            // Event ends here; an error if the length said more was coming.
            err_d[ERR_EARLY] = (rem_q != {{(LEN_W-1){1'b0}}, 1'b1});
            frag_cnt_d       = frag_cnt_q + 32'd1;
            state_d          = ST_IDLE;
          end else if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            // Length exhausted but input keeps going: discard the remainder.
            err_d[ERR_LONG] = 1'b1;
            frag_cnt_d      = frag_cnt_q + 32'd1;
            state_d         = ST_DRAIN;
          end else if (fcnt_q == {{(FIDX_W-1){1'b0}}, 1'b1}) begin
            fidx_d     = fidx_q + {{(FIDX_W-1){1'b0}}, 1'b1};
            frag_cnt_d = frag_cnt_q + 32'd1;
            state_d    = ST_HDR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (s_data_tvalid && s_data_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any event in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      alive_q    <= 1'b0;
      tag_q      <= {TAG_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      rem_q      <= {LEN_W{1'b0}};
      off_q      <= {LEN_W{1'b0}};
      fidx_q     <= {FIDX_W{1'b0}};
      fcnt_q     <= {FIDX_W{1'b0}};
      err_q      <= {ERR_W{1'b0}};
      evt_cnt_q  <= 32'd0;
      frag_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      tag_q      <= tag_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      off_q      <= off_d;
      fidx_q     <= fidx_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
      evt_cnt_q  <= evt_cnt_d;
      frag_cnt_q <= frag_cnt_d;
    end
  end

endmodule

// File: doc/event_fragmenter.md
EVENT_FRAGMENTER -- requirements
Module: event_fragmenter

Interface
REQ-001 Parameter FRAG_QWORDS, default 1024: maximum data qwords per output fragment; legal range 1..4095.
REQ-002 Parameter ETHCLKTYPE, default "NONE": clock-crossing tag for the clock domain.
REQ-003 aclk  input  1  clock; the event-readout Ethernet clock. This block has one clock only.
REQ-004 aresetn  input  1  reset; asynchronous, active-low.
REQ-005 s_ctrl_tdata/tvalid/tready  in/in/out  32/1/1  event control word.
- [19:0] event length in qwords.
- [31:20] event tag.
REQ-006 s_data_tdata/tvalid/tready/tlast  in/in/out/in  64/1/1/1  event data qwords; tlast marks the final qword of the event.
REQ-007 m_frag_tdata/tvalid/tready/tlast  out/in/out/out  64/1/1/1  fragment stream; tlast marks the end of each fragment.
REQ-008 err_o  output  3  one-cycle error pulses.
- [0] early: input tlast arrived before the length was reached.
- [1] long: length was reached without an input tlast.
- [2] zero: length field was 0.
REQ-009 event_count_o  output  32  count of control words accepted.
REQ-010 frag_count_o  output  32  count of fragments completed.

Function
REQ-011 The block SHALL implement the state machine IDLE, HDR, DATA, DRAIN.
REQ-012 In IDLE, s_ctrl_tready SHALL be 1, and s_data_tready and m_frag_tvalid SHALL be 0.
REQ-013 When the control handshake occurs in IDLE, the block SHALL latch tag and length, set remaining = length, set fidx = 0, set offset = 0, and go to HDR.
- m_frag_tvalid SHALL assert on the next cycle.
- This gives a latency of one cycle from control accept to header valid.
REQ-014 Each fragment SHALL begin with one header qword:
- [63:52] tag
- [51:40] fidx
- [39:20] total length
- [19:0] offset (qwords already sent for this event)
REQ-015 When the header handshake completes, the block SHALL go to DATA with fcnt = min(remaining, FRAG_QWORDS).
REQ-016 In DATA, the data stream SHALL pass through combinationally.
- m_frag_tdata = s_data_tdata.
- m_frag_tvalid = s_data_tvalid.
- s_data_tready = m_frag_tready.
- There SHALL be no bubbles between data qwords.
REQ-017 Each data handshake SHALL decrement both fcnt and remaining and increment offset.
- m_frag_tlast SHALL be 1 when fcnt == 1, or when s_data_tlast == 1.
REQ-018 When fcnt reaches 0 with remaining > 0 and no input tlast, the block SHALL increment fidx (wrapping modulo 4096), go to HDR, and increment frag_count_o.
REQ-019 When the final qword completes with remaining reaching 0 and s_data_tlast == 1, the block SHALL go to IDLE and increment frag_count_o.
REQ-020 When s_data_tlast arrives while remaining > 1, the block SHALL:
- end the fragment on that qword with tlast,
- pulse err_o[0],
- go to IDLE.
REQ-021 When remaining reaches 0 without s_data_tlast, the block SHALL:
- end the fragment with tlast,
- pulse err_o[1],
- go to DRAIN.
REQ-022 In DRAIN, s_data_tready SHALL be 1 and m_frag_tvalid SHALL be 0; input qwords SHALL be discarded up to and including the one with tlast, after which the block goes to IDLE.
REQ-023 A length of 0 SHALL produce a header-only fragment (tlast on the header, offset 0) with an err_o[2] pulse, followed by DRAIN.
REQ-024 While m_frag_tvalid is 1 and m_frag_tready is 0, m_frag_tdata and m_frag_tlast SHALL be held stable.
REQ-025 The counters SHALL be 32-bit and wrap modulo 2^32.
REQ-026 When length == FRAG_QWORDS, exactly one fragment SHALL be produced; no empty trailing fragment is allowed.

Reset
REQ-027 Assertion of aresetn low SHALL asynchronously force:
- state to IDLE,
- s_ctrl_tready=0, s_data_tready=0, m_frag_tvalid=0, m_frag_tlast=0,
- err_o=0, event_count_o=0, frag_count_o=0,
- all internal counters to 0.
REQ-028 s_ctrl_tready SHALL first assert on the first rising edge of aclk after aresetn deasserts.
REQ-029 Reset in the middle of an event SHALL abandon the event with no recovery; upstream is reset by the same event reset.

Structure
REQ-030 The header bit-field positions, the state enumeration, and the error bit indices SHALL live in a shared package, event_frag_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the header mux and pass-through SHALL be inline.

Verification
REQ-032 FRAG_QWORDS=4, ctrl {tag=0x123, len=10}, 10 qwords with tlast on the last -> three fragments of 4, 4, 2 data qwords; headers show fidx 0/1/2 and offsets 0/4/8; frag_count_o=3; no errors.
REQ-033 len=4, FRAG_QWORDS=4 -> one header plus 4 qwords, tlast on the 4th qword, then IDLE.
REQ-034 len=8, input tlast on the 3rd qword -> fragment ends on qword 3 and err_o[0] pulses once; the next control word is accepted.
REQ-035 len=3, input carries 6 qwords -> 3 qwords out with tlast, err_o[1] pulses, 3 qwords silently drained.
REQ-036 len=0 -> header-only fragment with tlast, err_o[2] pulses, the following data event is drained.
REQ-037 Random m_frag_tready backpressure on the REQ-032 stimulus -> identical output sequence, and data held stable while stalled.
